// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit bit encoder.
// State encoding, slot commands to the stuffer, the SYNC pattern and {dp,dm} line codes.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  typedef enum logic [1:0] {
    CmdData,
    CmdStuff,
    CmdSe0,
    CmdJ
  } slot_cmd_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_stuffer.sv
// Per-slot line driver: tracks consecutive ones, NRZI-encodes data/stuff bits and holds the
// registered {dp,dm} line state plus the stuffed-slot flag.
module usb_tx_stuffer
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       slot_i,
  input  slot_cmd_t  cmd_i,
  input  logic       bit_i,
  output logic       stuff_due_o,
  output logic [1:0] line_o,
  output logic       stuff_active_o
);

  localparam int unsigned CntW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CntW-1:0] DueVal = CntW'(STUFF_LIMIT - 1);

  logic [CntW-1:0] ones_cnt_q, ones_cnt_d;
  logic [1:0]      line_q, line_d;
  logic            stuff_active_q, stuff_active_d;
  logic [1:0]      toggled;

  // A one sent now completes the run, so the following slot must be stuffed.
  assign stuff_due_o    = (ones_cnt_q == DueVal);
  assign line_o         = line_q;
  assign stuff_active_o = stuff_active_q;

  always_comb begin
    ones_cnt_d     = ones_cnt_q;
    line_d         = line_q;
    stuff_active_d = stuff_active_q;
    toggled        = (line_q == LINE_J) ? LINE_K : LINE_J;
    if (slot_i) begin
      stuff_active_d = 1'b0;
      ones_cnt_d     = '0;
      unique case (cmd_i)
        CmdData: begin
          if (bit_i) begin
            ones_cnt_d = ones_cnt_q + 1'b1;
          end else begin
            line_d = toggled;
          end
        end
        CmdStuff: begin
          line_d         = toggled;
          stuff_active_d = 1'b1;
        end
        CmdSe0: line_d = LINE_SE0;
        CmdJ:   line_d = LINE_J;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_cnt_q     <= '0;
      line_q         <= LINE_J;
      stuff_active_q <= 1'b0;
    end else begin
      ones_cnt_q     <= ones_cnt_d;
      line_q         <= line_d;
      stuff_active_q <= stuff_active_d;
    end
  end

endmodule

// File: rtl/usb_tx_bit_encoder.sv
// USB full-speed transmit bit encoder: byte handshake, LSB-first serialiser, stuffing, NRZI, EOP.
// Define TX_SYNC_GEN_EN to prefix every packet with an internally generated SYNC byte.
module usb_tx_bit_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT  = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       stuff_active,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int unsigned EopW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [EopW-1:0] EopOne  = EopW'(1);
  localparam logic [EopW-1:0] EopBits = EopW'(EOP_SE0_BITS);

  state_t          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_last_q, hold_last_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      shift_q, shift_d;
  logic            shift_last_q, shift_last_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            sync_phase_q, sync_phase_d;
  logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;

  slot_cmd_t cmd;
  logic      cmd_bit;
  logic      start_byte;
  logic      send_bit;
  logic      bit_val;
  logic      stuff_due;
  logic [1:0] line;

  assign tx_ready    = ~hold_full_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_underrun = underrun_q;
  assign {d_plus, d_minus} = line;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_idx_d    = bit_idx_q;
    sync_phase_d = sync_phase_q;
    eop_cnt_d    = eop_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    cmd          = CmdJ;
    cmd_bit      = 1'b0;
    start_byte   = 1'b0;
    send_bit     = 1'b0;
    bit_val      = 1'b0;

    if (bit_strobe) begin
      unique case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            busy_d = 1'b1;
`ifdef TX_SYNC_GEN_EN
            state_d      = SYNC;
            sync_phase_d = 1'b1;
            send_bit     = 1'b1;
            bit_val      = SYNC_BYTE[0];
            bit_idx_d    = 4'd1;
`else
            start_byte = 1'b1;
`endif
          end
        end
        SYNC: begin
          if (bit_idx_q == 4'd8) begin
            start_byte = 1'b1;
          end else begin
            send_bit  = 1'b1;
            bit_val   = SYNC_BYTE[bit_idx_q[2:0]];
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
        SHIFT: begin
          if (bit_idx_q == 4'd8) begin
            // A held byte after a last byte belongs to the next packet.
            if (!shift_last_q && hold_full_q) begin
              start_byte = 1'b1;
            end else begin
              underrun_d = ~shift_last_q;
              state_d    = EOP_SE0;
              cmd        = CmdSe0;
              eop_cnt_d  = EopOne;
            end
          end else begin
            send_bit  = 1'b1;
            bit_val   = shift_q[bit_idx_q[2:0]];
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
        STUFF: begin
          cmd     = CmdStuff;
          state_d = sync_phase_q ? SYNC : SHIFT;
        end
        EOP_SE0: begin
          if (eop_cnt_q < EopBits) begin
            cmd       = CmdSe0;
            eop_cnt_d = eop_cnt_q + 1'b1;
          end else begin
            cmd     = CmdJ;
            state_d = EOP_J;
          end
        end
        EOP_J: begin
          cmd     = CmdJ;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (start_byte) begin
        shift_d      = hold_q;
        shift_last_d = hold_last_q;
        hold_full_d  = 1'b0;
        sync_phase_d = 1'b0;
        state_d      = SHIFT;
        send_bit     = 1'b1;
        bit_val      = hold_q[0];
        bit_idx_d    = 4'd1;
      end

      if (send_bit) begin
        cmd     = CmdData;
        cmd_bit = bit_val;
        if (bit_val && stuff_due) begin
          state_d = STUFF;
        end
      end
    end

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_idx_q    <= '0;
      sync_phase_q <= 1'b0;
      eop_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_idx_q    <= bit_idx_d;
      sync_phase_q <= sync_phase_d;
      eop_cnt_q    <= eop_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  usb_tx_stuffer #(
    .STUFF_LIMIT (STUFF_LIMIT)
  ) u_stuffer (
    .clk_i          (clk),
    .rst_ni         (n_rst),
    .slot_i         (bit_strobe),
    .cmd_i          (cmd),
    .bit_i          (cmd_bit),
    .stuff_due_o    (stuff_due),
    .line_o         (line),
    .stuff_active_o (stuff_active)
  );

endmodule
